// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// branch_ctrl : registered branch resolver with circular return-address stack
//               optional signed compares via BRANCH_SIGNED_CMP_EN  | Rev 1.0
// ============================================================================
module branch_ctrl #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic [2:0]                       func,
`ifdef BRANCH_SIGNED_CMP_EN
  input  logic                             cmp_signed,
`endif
  input  logic [ADDR_W-1:0]                pc,
  input  logic [ADDR_W-1:0]                target,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             taken,
  output logic [ADDR_W-1:0]                next_pc,
  output logic                             is_call,
  output logic                             is_ret,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_ovf,
  output logic                             ras_unf,
  input  logic                             flag_clr
);

  localparam int C_PW = $clog2(RAS_DEPTH);
  localparam int C_CW = $clog2(RAS_DEPTH+1);

  localparam logic [2:0] C_BEQ  = 3'b000;
  localparam logic [2:0] C_BNE  = 3'b001;
  localparam logic [2:0] C_BLT  = 3'b010;
  localparam logic [2:0] C_BLE  = 3'b011;
  localparam logic [2:0] C_BGT  = 3'b100;
  localparam logic [2:0] C_BGE  = 3'b101;
  localparam logic [2:0] C_CALL = 3'b110;

  logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
  logic [C_PW-1:0]   r_ptr;

  logic              w_accept;
  logic              w_sgn;
  logic [WIDTH-1:0]  w_msb;
  logic              w_lt;
  logic              w_eq;
  logic              w_cond;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_top;
  logic              w_taken;
  logic [ADDR_W-1:0] w_next;
  logic              w_call;
  logic              w_ret;
  logic              w_push;
  logic              w_pop;
  logic              w_set_ovf;
  logic              w_set_unf;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef BRANCH_SIGNED_CMP_EN
  assign w_sgn = cmp_signed;
`else
  assign w_sgn = 1'b0;
`endif

  // Flipping both sign bits turns a two's-complement compare into an unsigned one.
  assign w_msb    = {w_sgn, {(WIDTH-1){1'b0}}};
  assign w_lt     = (a ^ w_msb) < (b ^ w_msb);
  assign w_eq     = (a == b);
  assign w_empty  = (ras_count == '0);
  assign w_full   = (ras_count == C_CW'(RAS_DEPTH));
  assign w_pc_inc = pc + ADDR_W'(1);
  assign w_top    = r_stack[r_ptr - C_PW'(1)];

  always_comb begin
    w_cond = 1'b0;
    case (func)
      C_BEQ:   w_cond = w_eq;
      C_BNE:   w_cond = !w_eq;
      C_BLT:   w_cond = w_lt;
      C_BLE:   w_cond = w_lt || w_eq;
      C_BGT:   w_cond = !(w_lt || w_eq);
      C_BGE:   w_cond = !w_lt;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_taken   = 1'b0;
    w_next    = w_pc_inc;
    w_call    = 1'b0;
    w_ret     = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (func == C_CALL) begin
      w_taken   = 1'b1;
      w_next    = target;
      w_call    = 1'b1;
      w_push    = 1'b1;
      w_set_ovf = w_full;
    end else if (func == 3'b111) begin
      w_ret = 1'b1;
      if (w_empty) begin
        w_set_unf = 1'b1;
      end else begin
        w_taken = 1'b1;
        w_next  = w_top;
        w_pop   = 1'b1;
      end
    end else if (w_cond) begin
      w_taken = 1'b1;
      w_next  = target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      taken     <= 1'b0;
      next_pc   <= '0;
      is_call   <= 1'b0;
      is_ret    <= 1'b0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
      r_ptr     <= '0;
    end else begin
      if (w_accept) begin
        out_valid <= 1'b1;
        taken     <= w_taken;
        next_pc   <= w_next;
        is_call   <= w_call;
        is_ret    <= w_ret;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A push onto a full stack overwrites the oldest slot; count saturates.
      if (w_accept && w_push) begin
        r_ptr <= r_ptr + C_PW'(1);
        if (!w_full) ras_count <= ras_count + C_CW'(1);
      end else if (w_accept && w_pop) begin
        r_ptr     <= r_ptr - C_PW'(1);
        ras_count <= ras_count - C_CW'(1);
      end
      ras_ovf <= (w_accept && w_set_ovf) || (ras_ovf && !flag_clr);
      ras_unf <= (w_accept && w_set_unf) || (ras_unf && !flag_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_push) r_stack[r_ptr] <= w_pc_inc;
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_ctrl : directed scoreboard bench for branch_ctrl  | Rev 1.0
// ============================================================================
module tb_branch_ctrl;

  localparam int WIDTH     = 16;
  localparam int ADDR_W    = 16;
  localparam int RAS_DEPTH = 8;
  localparam int CW        = $clog2(RAS_DEPTH+1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [2:0]        func;
  logic              cmp_signed;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic              out_valid;
  logic              out_ready;
  logic              taken;
  logic [ADDR_W-1:0] next_pc;
  logic              is_call;
  logic              is_ret;
  logic [CW-1:0]     ras_count;
  logic              ras_ovf;
  logic              ras_unf;
  logic              flag_clr;

  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] next_pc;
    logic              is_call;
    logic              is_ret;
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic              unf;
  } exp_t;

  exp_t              sb[$];
  logic [ADDR_W-1:0] m_stack[$];
  logic              m_ovf;
  logic              m_unf;
  int                errors;
  int                checks;

  branch_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func),
`ifdef BRANCH_SIGNED_CMP_EN
    .cmp_signed(cmp_signed),
`endif
    .pc(pc), .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .next_pc(next_pc), .is_call(is_call), .is_ret(is_ret),
    .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf), .flag_clr(flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a queue used as a bounded stack that drops its oldest entry.
  function automatic exp_t model(input logic [2:0] f, input logic [WIDTH-1:0] fa, fb,
                                 input logic [ADDR_W-1:0] fpc, ftgt, input logic sg, clr);
    exp_t e;
    logic c, so, su;
    logic signed [WIDTH-1:0] sa, sbv;
    logic [ADDR_W-1:0] inc;
    sa = fa; sbv = fb; inc = fpc + ADDR_W'(1);
    e = '0; e.next_pc = inc; so = 1'b0; su = 1'b0; c = 1'b0;
    case (f)
      3'd0: c = (fa == fb);
      3'd1: c = (fa != fb);
      3'd2: c = sg ? (sa <  sbv) : (fa <  fb);
      3'd3: c = sg ? (sa <= sbv) : (fa <= fb);
      3'd4: c = sg ? (sa >  sbv) : (fa >  fb);
      3'd5: c = sg ? (sa >= sbv) : (fa >= fb);
      default: c = 1'b0;
    endcase
    if (f < 3'd6) begin
      e.taken = c;
      if (c) e.next_pc = ftgt;
    end else if (f == 3'd6) begin
      e.taken = 1'b1; e.is_call = 1'b1; e.next_pc = ftgt;
      if (m_stack.size() == RAS_DEPTH) begin
        void'(m_stack.pop_front());
        so = 1'b1;
      end
      m_stack.push_back(inc);
    end else begin
      e.is_ret = 1'b1;
      if (m_stack.size() == 0) su = 1'b1;
      else begin
        e.taken = 1'b1;
        e.next_pc = m_stack.pop_back();
      end
    end
    m_ovf = so || (m_ovf && !clr);
    m_unf = su || (m_unf && !clr);
    e.cnt = CW'(m_stack.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    return e;
  endfunction

  task automatic send(input logic [2:0] f, input logic [WIDTH-1:0] fa, fb,
                      input logic [ADDR_W-1:0] fpc, ftgt, input logic sg = 1'b0,
                      input logic clr = 1'b0);
    in_valid = 1'b1; func = f; a = fa; b = fb; pc = fpc; target = ftgt;
    cmp_signed = sg; flag_clr = clr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) sb.push_back(model(f, fa, fb, fpc, ftgt, sg, clr));
    @(posedge clk); #1;
    in_valid = 1'b0; flag_clr = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("taken",     {31'd0, taken},     {31'd0, e.taken});
        chk("next_pc",   32'(next_pc),       32'(e.next_pc));
        chk("is_call",   {31'd0, is_call},   {31'd0, e.is_call});
        chk("is_ret",    {31'd0, is_ret},    {31'd0, e.is_ret});
        chk("ras_count", 32'(ras_count),     32'(e.cnt));
        chk("ras_ovf",   {31'd0, ras_ovf},   {31'd0, e.ovf});
        chk("ras_unf",   {31'd0, ras_unf},   {31'd0, e.unf});
      end
    end
  end

  initial begin
    errors = 0; checks = 0; m_ovf = 1'b0; m_unf = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1; func = 3'b110; a = '0; b = '0; pc = 16'h0001;
    target = 16'h0002; cmp_signed = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;

    // Reset held with a request pending: nothing may be accepted.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ras_count", 32'(ras_count), 32'd0);
    chk("rst_ovf", {31'd0, ras_ovf}, 32'd0);
    chk("rst_unf", {31'd0, ras_unf}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_next_pc", 32'(next_pc), 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    send(3'b000, 16'd5, 16'd5, 16'h0010, 16'h0080);
    send(3'b100, 16'd3, 16'd7, 16'hFFFF, 16'h0040);
    send(3'b011, 16'd7, 16'd7, 16'h0020, 16'h0044);
    send(3'b001, 16'd9, 16'd9, 16'h0030, 16'h0048);
    send(3'b010, 16'hFFFF, 16'h0001, 16'h0031, 16'h004C);
    send(3'b101, 16'h1234, 16'h1233, 16'h0032, 16'h0050);
    send(3'b100, 16'h8000, 16'h7FFF, 16'h0033, 16'h0054);

    // Nested call/return, back to back.
    send(3'b110, '0, '0, 16'h0100, 16'h0500);
    send(3'b110, '0, '0, 16'h0200, 16'h0600);
    send(3'b111, '0, '0, 16'h0601, 16'h0000);
    send(3'b111, '0, '0, 16'h0501, 16'h0000);
    send(3'b110, '0, '0, 16'hFFFF, 16'h0700);
    send(3'b111, '0, '0, 16'h0701, 16'h0000);

    // Underflow, standalone clear, then clear racing a fresh underflow.
    send(3'b111, '0, '0, 16'h0900, 16'h0000);
    @(posedge clk); #1;
    flag_clr = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    @(negedge clk);
    chk("unf_cleared", {31'd0, ras_unf}, 32'd0);
    @(posedge clk); #1;
    send(3'b111, '0, '0, 16'h0910, 16'h0000, 1'b0, 1'b1);

    // Overflow: RAS_DEPTH+1 calls, then drain the stack completely.
    for (int i = 0; i <= RAS_DEPTH; i++)
      send(3'b110, '0, '0, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
    for (int i = 0; i < RAS_DEPTH; i++)
      send(3'b111, '0, '0, 16'h3000 + 16'(i), 16'h0000);
    send(3'b111, '0, '0, 16'h3100, 16'h0000, 1'b0, 1'b1);

    // Backpressure: result held for 3 cycles while a RET waits.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'b110, '0, '0, 16'h0300, 16'h0700);
    in_valid = 1'b1; func = 3'b111; pc = 16'h0400; target = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_next_pc", 32'(next_pc), 32'h0700);
      chk("bp_ras_count", 32'(ras_count), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'b111, '0, '0, 16'h0400, 16'h0000);
    send(3'b111, '0, '0, 16'h0410, 16'h0000);

`ifdef BRANCH_SIGNED_CMP_EN
    send(3'b010, 16'hFFFF, 16'h0001, 16'h0500, 16'h0A00, 1'b1);
    send(3'b010, 16'hFFFF, 16'h0001, 16'h0501, 16'h0A04, 1'b0);
    send(3'b101, 16'h8000, 16'h7FFF, 16'h0502, 16'h0A08, 1'b1);
    send(3'b000, 16'hFFFF, 16'hFFFF, 16'h0503, 16'h0A0C, 1'b1);
`endif

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
